tlb_maint_unit: RTL and testbench

//  Executes CP0 TLB instructions (TLBP/TLBR/TLBWI/TLBWR) against the tlb array: the writer/prober

---
 rtl/tlb_maint_unit.sv | 205 ++++++++++++++++++++
 tb/tb_tlb_maint_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_maint_unit.sv
// tlb_maint_unit: executes the CP0 TLB instructions TLBP/TLBR/TLBWI/TLBWR
// against the tlb array. It drives the tlb write port, scans the tlb read
// port, owns the Random register and, optionally, the post-reset
// invalidation sweep. One command in flight; multi-cycle.
//
// Build option: define TLB_INIT_EN to sweep all entries to zero after reset
// (TLB_ENTRIES cycles, cmd_ready low). Without it the unit comes out of reset
// idle and software must invalidate the array.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only when idle)
//   cmd_op                    00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
//   cp0_index, cp0_wired      Index and Wired registers
//   cp0_mask, cp0_entryhi,
//   cp0_entrylo0/1            PageMask[24:13], EntryHi, EntryLo0/1 operands
//   cp0_random                Random register
//   done                      one-cycle completion pulse
//   probe_hit, probe_idx      TLBP result (held until next TLBP)
//   rd_mask, rd_entryhi,
//   rd_entrylo0/1             TLBR result (held until next TLBR)
//   tlb_wen, tlb_widx, tlb_w* tlb write port
//   tlb_ridx, tlb_r*          tlb read port, data returns one cycle later
module tlb_maint_unit #(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic [11:0]      cp0_mask,
  input  logic [31:0]      cp0_entryhi,
  input  logic [31:0]      cp0_entrylo0,
  input  logic [31:0]      cp0_entrylo1,
  output logic [IDX_W-1:0] cp0_random,
  output logic             done,
  output logic             probe_hit,
  output logic [IDX_W-1:0] probe_idx,
  output logic [11:0]      rd_mask,
  output logic [31:0]      rd_entryhi,
  output logic [31:0]      rd_entrylo0,
  output logic [31:0]      rd_entrylo1,
  output logic             tlb_wen,
  output logic [IDX_W-1:0] tlb_widx,
  output logic [11:0]      tlb_wmask,
  output logic [31:0]      tlb_wentryhi,
  output logic [31:0]      tlb_wentrylo0,
  output logic [31:0]      tlb_wentrylo1,
  output logic [IDX_W-1:0] tlb_ridx,
  input  logic [11:0]      tlb_rmask,
  input  logic [31:0]      tlb_rentryhi,
  input  logic [31:0]      tlb_rentrylo0,
  input  logic [31:0]      tlb_rentrylo1
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_PROBE = 3'd4;

`ifdef TLB_INIT_EN
  localparam logic [2:0] S_RESET = S_INIT;
`else
  localparam logic [2:0] S_RESET = S_IDLE;
`endif

  localparam logic [1:0]       OP_TLBP  = 2'b00;
  localparam logic [1:0]       OP_TLBR  = 2'b01;
  localparam logic [1:0]       OP_TLBWI = 2'b10;
  localparam logic [1:0]       OP_TLBWR = 2'b11;
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [IDX_W:0]   CNT_END  = (IDX_W+1)'(TLB_ENTRIES);

  logic [2:0]       state;
  logic [IDX_W:0]   cnt;        // sweep index / phase / probe cycle count
  logic [IDX_W-1:0] idx_q;
  logic [11:0]      mask_q;
  logic [31:0]      hi_q, lo0_q, lo1_q;
  logic [IDX_W-1:0] random_q;
  logic [11:0]      rmask_q;
  logic [31:0]      rhi_q, rlo0_q, rlo1_q;
  logic             hit_q;
  logic [IDX_W-1:0] pidx_q;

  logic             live;
  logic [18:0]      vmask;
  logic             match;
  logic             probe_end;
  logic             read_end;
  logic [IDX_W:0]   wired_p1;
  logic [IDX_W-1:0] match_idx;

  assign live      = ~rst;
  assign vmask     = ~{7'b0, tlb_rmask};
  assign match     = ((tlb_rentryhi[31:13] & vmask) == (hi_q[31:13] & vmask)) &&
                     ((tlb_rentrylo0[0] & tlb_rentrylo1[0]) ||
                      (tlb_rentryhi[7:0] == hi_q[7:0]));
  // During PROBE, cnt==k+1 means read data for entry k is on the port.
  assign match_idx = IDX_W'(cnt - (IDX_W+1)'(1));
  assign probe_end = (state == S_PROBE) && (cnt != '0) && (match || cnt == CNT_END);
  assign read_end  = (state == S_READ) && (cnt != '0);
  assign wired_p1  = {1'b0, cp0_wired} + (IDX_W+1)'(1);

  assign cmd_ready  = live && (state == S_IDLE);
  assign done       = live && ((state == S_WRITE) || read_end || probe_end);
  assign cp0_random = random_q;

  assign tlb_wen       = live && ((state == S_INIT) || (state == S_WRITE));
  assign tlb_widx      = (state == S_WRITE) ? idx_q :
                         (state == S_INIT)  ? cnt[IDX_W-1:0] : '0;
  assign tlb_wmask     = (state == S_WRITE) ? mask_q : '0;
  assign tlb_wentryhi  = (state == S_WRITE) ? hi_q   : '0;
  assign tlb_wentrylo0 = (state == S_WRITE) ? lo0_q  : '0;
  assign tlb_wentrylo1 = (state == S_WRITE) ? lo1_q  : '0;
  assign tlb_ridx      = (state == S_READ)  ? idx_q  :
                         (state == S_PROBE) ? cnt[IDX_W-1:0] : '0;

  // Results are visible in the done cycle by bypassing the read port; the
  // registered copies hold them afterwards.
  assign rd_mask     = (live && read_end) ? tlb_rmask     : rmask_q;
  assign rd_entryhi  = (live && read_end) ? tlb_rentryhi  : rhi_q;
  assign rd_entrylo0 = (live && read_end) ? tlb_rentrylo0 : rlo0_q;
  assign rd_entrylo1 = (live && read_end) ? tlb_rentrylo1 : rlo1_q;
  assign probe_hit   = (live && probe_end) ? match : hit_q;
  assign probe_idx   = (live && probe_end) ? (match ? match_idx : '0) : pidx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      cnt      <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
      hi_q     <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
      random_q <= LAST;
      rmask_q  <= '0;
      rhi_q    <= '0;
      rlo0_q   <= '0;
      rlo1_q   <= '0;
      hit_q    <= 1'b0;
      pidx_q   <= '0;
    end else begin
      // Reload one step early so the sequence never lands on a wired entry.
      if ({1'b0, random_q} <= wired_p1) random_q <= LAST;
      else                              random_q <= random_q - IDX_W'(1);

      case (state)
        S_INIT: begin
          if (cnt[IDX_W-1:0] == LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + (IDX_W+1)'(1);
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            mask_q <= cp0_mask;
            hi_q   <= cp0_entryhi;
            lo0_q  <= cp0_entrylo0;
            lo1_q  <= cp0_entrylo1;
            cnt    <= '0;
            case (cmd_op)
              OP_TLBP:  state <= S_PROBE;
              OP_TLBR:  begin idx_q <= cp0_index; state <= S_READ;  end
              OP_TLBWI: begin idx_q <= cp0_index; state <= S_WRITE; end
              OP_TLBWR: begin idx_q <= random_q;  state <= S_WRITE; end
            endcase
          end
        end
        S_WRITE: state <= S_IDLE;
        S_READ: begin
          if (cnt == '0) begin
            cnt <= (IDX_W+1)'(1);
          end else begin
            rmask_q <= tlb_rmask;
            rhi_q   <= tlb_rentryhi;
            rlo0_q  <= tlb_rentrylo0;
            rlo1_q  <= tlb_rentrylo1;
            cnt     <= '0;
            state   <= S_IDLE;
          end
        end
        S_PROBE: begin
          if (probe_end) begin
            hit_q  <= match;
            pidx_q <= match ? match_idx : '0;
            cnt    <= '0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + (IDX_W+1)'(1);
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_maint_unit.sv
// Testbench for tlb_maint_unit: directed commands against a behavioural tlb
// array; expected writes and completions are queued at issue time and
// checked by independent monitors.
module tb_tlb_maint_unit;
  localparam int N = 32;
  localparam int W = 5;

  localparam logic [31:0] LO0 = 32'h000C_CCDE;  // 0x3333<<6 | 0x1E
  localparam logic [31:0] LO1 = 32'h0011_111E;  // 0x4444<<6 | 0x1E

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cp0_index, cp0_wired, cp0_random;
  logic [11:0]   cp0_mask;
  logic [31:0]   cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic          done, probe_hit;
  logic [W-1:0]  probe_idx;
  logic [11:0]   rd_mask;
  logic [31:0]   rd_entryhi, rd_entrylo0, rd_entrylo1;
  logic          tlb_wen;
  logic [W-1:0]  tlb_widx, tlb_ridx;
  logic [11:0]   tlb_wmask, tlb_rmask;
  logic [31:0]   tlb_wentryhi, tlb_wentrylo0, tlb_wentrylo1;
  logic [31:0]   tlb_rentryhi, tlb_rentrylo0, tlb_rentrylo1;

  tlb_maint_unit #(.TLB_ENTRIES(N), .IDX_W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
    .cp0_mask(cp0_mask), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_random(cp0_random), .done(done), .probe_hit(probe_hit),
    .probe_idx(probe_idx), .rd_mask(rd_mask), .rd_entryhi(rd_entryhi),
    .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
    .tlb_wen(tlb_wen), .tlb_widx(tlb_widx), .tlb_wmask(tlb_wmask),
    .tlb_wentryhi(tlb_wentryhi), .tlb_wentrylo0(tlb_wentrylo0),
    .tlb_wentrylo1(tlb_wentrylo1), .tlb_ridx(tlb_ridx),
    .tlb_rmask(tlb_rmask), .tlb_rentryhi(tlb_rentryhi),
    .tlb_rentrylo0(tlb_rentrylo0), .tlb_rentrylo1(tlb_rentrylo1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural tlb array: synchronous write, one-cycle read latency.
  logic [107:0] mem [N] = '{default: '0};
  always @(posedge clk) begin
    if (tlb_wen) mem[tlb_widx] <= {tlb_wmask, tlb_wentryhi, tlb_wentrylo0, tlb_wentrylo1};
    {tlb_rmask, tlb_rentryhi, tlb_rentrylo0, tlb_rentrylo1} <= mem[tlb_ridx];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [W-1:0] idx;
    logic [11:0] mask;
    logic [31:0] hi, lo0, lo1;
  } wr_t;

  typedef struct {
    int          cyc;
    int          kind;   // 0 write, 1 read, 2 probe
    logic        hit;
    logic [W-1:0] idx;
    logic [11:0] mask;
    logic [31:0] hi, lo0, lo1;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t wm;
  dn_t dm;

  // Write-port monitor
  always @(negedge clk) begin
    if (tlb_wen) begin
      if (wq.size() == 0) chk("wen_unexpected", tlb_wen, 1'b0);
      else begin
        wm = wq.pop_front();
        chk("wr_cycle", cyc, wm.cyc);
        chk("wr_idx", tlb_widx, wm.idx);
        chk("wr_mask", tlb_wmask, wm.mask);
        chk("wr_hi", tlb_wentryhi, wm.hi);
        chk("wr_lo0", tlb_wentrylo0, wm.lo0);
        chk("wr_lo1", tlb_wentrylo1, wm.lo1);
      end
    end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
      wm = wq.pop_front();
      chk("wr_missing", tlb_wen, 1'b1);
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (done) begin
      if (dq.size() == 0) chk("done_unexpected", done, 1'b0);
      else begin
        dm = dq.pop_front();
        chk("done_cycle", cyc, dm.cyc);
        if (dm.kind == 1) begin
          chk("rd_mask", rd_mask, dm.mask);
          chk("rd_entryhi", rd_entryhi, dm.hi);
          chk("rd_entrylo0", rd_entrylo0, dm.lo0);
          chk("rd_entrylo1", rd_entrylo1, dm.lo1);
        end else if (dm.kind == 2) begin
          chk("probe_hit", probe_hit, dm.hit);
          if (dm.hit) chk("probe_idx", probe_idx, dm.idx);
        end
      end
    end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
      dm = dq.pop_front();
      chk("done_missing", done, 1'b1);
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset(output int base);
    @(posedge clk); #1;
    rst  = 1'b1;
    base = cyc + 1;
`ifdef TLB_INIT_EN
    for (int i = 0; i < N; i++) wq.push_back('{base + i, W'(i), 12'h0, 32'h0, 32'h0, 32'h0});
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] index,
                       input logic [11:0] mask, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1,
                       output int a);
    int t = 0;
    while (!cmd_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    a = cyc;
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1'b1);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cp0_index    = index;
    cp0_mask     = mask;
    cp0_entryhi  = hi;
    cp0_entrylo0 = lo0;
    cp0_entrylo1 = lo1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;   // later operand changes must not matter
  endtask

  task automatic drain();
    int t = 0;
    while ((wq.size() != 0 || dq.size() != 0) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (wq.size() != 0 || dq.size() != 0) chk("drain_timeout", wq.size() + dq.size(), 0);
  endtask

  task automatic push_write(input int a, input logic [W-1:0] idx, input logic [11:0] mask,
                            input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    wq.push_back('{a + 1, idx, mask, hi, lo0, lo1});
    dq.push_back('{a + 1, 0, 1'b0, '0, 12'h0, 32'h0, 32'h0, 32'h0});
  endtask

  int base, a;
  logic [W-1:0] ridx;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cp0_index = '0; cp0_wired = '0;
    cp0_mask = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    repeat (3) @(posedge clk);

    // Reset state
    do_reset(base);
    @(negedge clk);
    chk("rst_random", cp0_random, 5'd31);
    chk("rst_done", done, 1'b0);
    chk("rst_probe_hit", probe_hit, 1'b0);
    chk("rst_probe_idx", probe_idx, 5'd0);
    chk("rst_rd_entryhi", rd_entryhi, 32'h0);
    chk("rst_rd_mask", rd_mask, 12'h0);
`ifdef TLB_INIT_EN
    chk("init_ready_c1", cmd_ready, 1'b0);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      if (j == 31) chk("init_ready_c32", cmd_ready, 1'b0);
      if (j == 32) chk("init_ready_c33", cmd_ready, 1'b1);
    end
`else
    chk("idle_ready_c1", cmd_ready, 1'b1);
`endif
    @(posedge clk); #1;

    // TLBWI index 1, then TLBWI index 31 (global, masked)
    issue(2'b10, 5'd1, 12'h000, 32'h0000_4000, LO0, LO1, a);
    push_write(a, 5'd1, 12'h000, 32'h0000_4000, LO0, LO1);
    drain();
    issue(2'b10, 5'd31, 12'h003, 32'h0008_0055, 32'h1, 32'h1, a);
    push_write(a, 5'd31, 12'h003, 32'h0008_0055, 32'h1, 32'h1);
    drain();

    // TLBR index 1 and index 31
    issue(2'b01, 5'd1, 12'hFFF, 32'hDEAD_BEEF, 32'h0, 32'h0, a);
    dq.push_back('{a + 2, 1, 1'b0, '0, 12'h000, 32'h0000_4000, LO0, LO1});
    drain();
    issue(2'b01, 5'd31, 12'h000, 32'h0, 32'h0, 32'h0, a);
    dq.push_back('{a + 2, 1, 1'b0, '0, 12'h003, 32'h0008_0055, 32'h1, 32'h1});
    drain();

    // TLBP: hit at 1; hit at last entry via mask + G; ASID miss
    issue(2'b00, 5'd0, 12'h0, 32'h0000_4000, 32'h0, 32'h0, a);
    dq.push_back('{a + 3, 2, 1'b1, 5'd1, 12'h0, 32'h0, 32'h0, 32'h0});
    drain();
    issue(2'b00, 5'd0, 12'h0, 32'h0008_6077, 32'h0, 32'h0, a);
    dq.push_back('{a + 33, 2, 1'b1, 5'd31, 12'h0, 32'h0, 32'h0, 32'h0});
    drain();
    issue(2'b00, 5'd0, 12'h0, 32'h0000_4001, 32'h0, 32'h0, a);
    dq.push_back('{a + 33, 2, 1'b0, '0, 12'h0, 32'h0, 32'h0, 32'h0});
    // a command while busy must be ignored
    cmd_valid = 1'b1; cmd_op = 2'b10; cp0_index = 5'd5;
    repeat (8) begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
    drain();
    @(negedge clk);
    chk("rd_hold", rd_entryhi, 32'h0008_0055);
    chk("probe_hold", probe_hit, 1'b0);
    @(posedge clk); #1;

    // Random with wired=8, then TLBWR
    cp0_wired = 5'd8;
    do_reset(base);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      chk("random_seq", cp0_random, 64'(31 - (j % 23)));
    end
    @(posedge clk); #1;
    issue(2'b11, 5'd0, 12'h000, 32'h0000_A000, 32'h0000_0042, 32'h0000_0086, a);
    ridx = W'(31 - ((a - base) % 23));
    push_write(a, ridx, 12'h000, 32'h0000_A000, 32'h0000_0042, 32'h0000_0086);
    drain();

    // wired at N-1 pins Random
    cp0_wired = 5'd31;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("random_pinned", cp0_random, 5'd31);
    end
    @(posedge clk); #1;
    cp0_wired = 5'd0;

    // Reset in the middle of a TLBP aborts it
    issue(2'b00, 5'd0, 12'h0, 32'h0000_4001, 32'h0, 32'h0, a);
    repeat (4) begin @(posedge clk); #1; end
    do_reset(base);
`ifdef TLB_INIT_EN
    cmd_valid = 1'b1; cmd_op = 2'b10; cp0_index = 5'd7;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("init_ignores_cmd", cmd_ready, 1'b0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`else
    @(negedge clk);
    chk("rst_abort_idle", cmd_ready, 1'b1);
    chk("rst_abort_done", done, 1'b0);
    @(posedge clk); #1;
`endif
    repeat (40) begin @(posedge clk); #1; end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
